activation_buffer: RTL and testbench

Ping-pong activation store between the CORDIC activation-function unit and the MAC input of the inference datapath. Captures one layer's neuron outputs as they leave the AF stage. On the controller's layer-commit strobe it swaps banks so those outputs become the next layer's inputs. It also muxes in the external network input for layer 0 under `output_sel`.

---
 rtl/actbuf_pkg.sv | 12 +
 rtl/activation_buffer_if.sv | 42 ++++
 rtl/actbuf_bank.sv | 29 ++
 rtl/activation_buffer.sv | 157 +++++++++++++++
 tb/tb_activation_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/actbuf_pkg.sv
// actbuf_pkg -- shared widths and the activation word type for the
// activation_buffer slice.
//   DATA_W : activation word width (two's complement fixed point)
//   DEPTH  : entries per bank (max neurons per layer)
//   ADDR_W : neuron index width, 2**ADDR_W >= DEPTH
package actbuf_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef logic signed [DATA_W-1:0] act_t;
endpackage

// File: rtl/activation_buffer_if.sv
// activation_buffer_if -- every non-clock signal of the activation buffer.
//   master : controller / AF stage / external input memory side
//   slave  : activation_buffer
// Handshakes: af_valid is a one-way strobe (no ready); a write presented
// while the write bank is full is dropped and reported through the sticky
// overflow flag. rd_en is likewise a one-way strobe; every accepted read
// returns exactly one rd_valid pulse a fixed two cycles later, and
// rd_data/rd_oob are only meaningful while rd_valid is high.
interface activation_buffer_if #(
  parameter int DATA_W = actbuf_pkg::DATA_W,
  parameter int ADDR_W = actbuf_pkg::ADDR_W
);
  logic              start;
  logic              af_valid;
  logic [DATA_W-1:0] af_data;
  logic              output_wr_en;
  logic              output_sel;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_oob;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W:0]   layer_count;
  logic              overflow;

  modport master (
    output start, af_valid, af_data, output_wr_en, output_sel, rd_en,
           rd_addr, ext_data,
    input  ext_addr, rd_data, rd_valid, rd_oob, wr_count, layer_count,
           overflow
  );

  modport slave (
    input  start, af_valid, af_data, output_wr_en, output_sel, rd_en,
           rd_addr, ext_data,
    output ext_addr, rd_data, rd_valid, rd_oob, wr_count, layer_count,
           overflow
  );
endinterface

// File: rtl/actbuf_bank.sv
// actbuf_bank -- one activation bank: simple dual-port RAM, one write
// port and one registered read port, single clock.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write word
//   raddr : read index, data appears on rdata after the next edge
//   rdata : registered read word
module actbuf_bank #(
  parameter int DATA_W = actbuf_pkg::DATA_W,
  parameter int DEPTH  = actbuf_pkg::DEPTH,
  parameter int ADDR_W = actbuf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import actbuf_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/activation_buffer.sv
// activation_buffer -- ping-pong activation store between the AF stage and
// the MAC input. AF results fill the write bank; a rising edge on
// output_wr_en commits the layer (swaps banks and latches the count) so the
// results become the next layer's inputs. Reads return either the read bank
// (output_sel=1) or the external network input (output_sel=0), both with a
// fixed two-cycle latency.
// Ports: clk, rst (synchronous, active-high), bus (activation_buffer_if.slave:
// start, af_valid/af_data, output_wr_en, output_sel, rd_en/rd_addr,
// ext_addr/ext_data, rd_data/rd_valid/rd_oob, wr_count, layer_count,
// overflow).
// Build option ACTBUF_OVF_CHECK_EN: when defined, writes to a full bank are
// dropped with a sticky overflow flag and reads past the committed count
// return 0 with rd_oob. When undefined, the write pointer wraps modulo DEPTH,
// overflow and rd_oob are tied low and out-of-range reads return stale data.
module activation_buffer #(
  parameter int DATA_W = actbuf_pkg::DATA_W,
  parameter int DEPTH  = actbuf_pkg::DEPTH,
  parameter int ADDR_W = actbuf_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  activation_buffer_if.slave bus
);
  import actbuf_pkg::*;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
`ifdef ACTBUF_OVF_CHECK_EN
  localparam logic [ADDR_W:0] FULL_PTR = DEPTH[ADDR_W:0];
`else
  localparam logic [ADDR_W:0] LAST_PTR = DEPTH[ADDR_W:0] - PTR_ONE;
`endif

  logic              wr_bank;
  logic              commit_q;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   wr_ptr_nxt;
  logic [ADDR_W:0]   layer_count;
  logic              commit;
  logic              wr_accept;
  logic              clear;
  logic              rd_oob_issue;
  logic [DATA_W-1:0] bank_q0;
  logic [DATA_W-1:0] bank_q1;

  // Read pipeline, stage 1 (after the issue edge) and stage 2 (outputs).
  logic              rd_v1;
  logic              rd_sel1;
  logic              rd_bank1;
  logic              rd_oob1;
  logic [ADDR_W-1:0] ext_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_oob_q;

  assign clear  = rst | bus.start;
  assign commit = bus.output_wr_en & ~commit_q;

  always_comb begin
    wr_accept    = bus.af_valid;
    wr_ptr_nxt   = wr_ptr + PTR_ONE;
    rd_oob_issue = 1'b0;
`ifdef ACTBUF_OVF_CHECK_EN
    if (wr_ptr >= FULL_PTR) wr_accept = 1'b0;
    // Compared against the pre-commit count, matching the pre-commit bank.
    rd_oob_issue = ({1'b0, bus.rd_addr} >= layer_count);
`else
    if (wr_ptr == LAST_PTR) wr_ptr_nxt = '0;
`endif
  end

  actbuf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_accept & ~wr_bank & ~clear),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.af_data),
    .raddr (bus.rd_addr),
    .rdata (bank_q0)
  );

  actbuf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_accept & wr_bank & ~clear),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.af_data),
    .raddr (bus.rd_addr),
    .rdata (bank_q1)
  );

  // Pointer, bank select and commit edge detect. start keeps tracking
  // output_wr_en so a level already high across start does not fire a
  // spurious commit on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) commit_q <= 1'b0;
    else     commit_q <= bus.output_wr_en;

    if (clear) begin
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      layer_count <= '0;
    end else if (commit) begin
      // A write accepted on the commit edge belongs to the committed layer.
      layer_count <= wr_accept ? wr_ptr_nxt : wr_ptr;
      wr_bank     <= ~wr_bank;
      wr_ptr      <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr_nxt;
    end
  end

`ifdef ACTBUF_OVF_CHECK_EN
  logic overflow_q;
  always_ff @(posedge clk) begin
    if (clear)                           overflow_q <= 1'b0;
    else if (bus.af_valid && !wr_accept) overflow_q <= 1'b1;
  end
  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  // The bank is chosen at issue time, so a read in the commit cycle sees
  // the bank that was readable before the swap.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_v1      <= 1'b0;
      rd_sel1    <= 1'b0;
      rd_bank1   <= 1'b0;
      rd_oob1    <= 1'b0;
      ext_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_v1 <= bus.rd_en;
      if (bus.rd_en) begin
        rd_sel1    <= bus.output_sel;
        rd_bank1   <= ~wr_bank;
        rd_oob1    <= bus.output_sel & rd_oob_issue;
        ext_addr_q <= bus.rd_addr;
      end
      rd_valid_q <= rd_v1;
      rd_oob_q   <= rd_v1 & rd_oob1;
      if (rd_v1) begin
        if (!rd_sel1)     rd_data_q <= bus.ext_data;
        else if (rd_oob1) rd_data_q <= '0;
        else              rd_data_q <= rd_bank1 ? bank_q1 : bank_q0;
      end
    end
  end

  assign bus.ext_addr    = ext_addr_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_oob      = rd_oob_q;
  assign bus.wr_count    = wr_ptr;
  assign bus.layer_count = layer_count;
endmodule

// File: tb/tb_activation_buffer.sv
// tb_activation_buffer -- directed testbench for activation_buffer.
// Honours ACTBUF_OVF_CHECK_EN: expectations for full-bank writes and
// out-of-range reads follow whichever build is compiled.
`timescale 1ns/1ps
module tb_activation_buffer;
  import actbuf_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  activation_buffer_if bus ();

  activation_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External input memory: combinational, word = 0x5000 | address.
  assign bus.ext_data = 16'h5000 | {{(DATA_W-ADDR_W){1'b0}}, bus.ext_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic af_write(input logic [15:0] v);
    bus.af_valid = 1'b1;
    bus.af_data  = v;
    tick();
    bus.af_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.output_wr_en = 1'b1;
    tick();
    bus.output_wr_en = 1'b0;
    tick();
  endtask

  task automatic read_one(input logic [5:0] a, input logic sel);
    bus.rd_en      = 1'b1;
    bus.rd_addr    = a;
    bus.output_sel = sel;
    tick();
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_data"},     bus.rd_data, 0);
    check({tag, "_rd_valid"},    bus.rd_valid, 0);
    check({tag, "_rd_oob"},      bus.rd_oob, 0);
    check({tag, "_ext_addr"},    bus.ext_addr, 0);
    check({tag, "_wr_count"},    bus.wr_count, 0);
    check({tag, "_layer_count"}, bus.layer_count, 0);
    check({tag, "_overflow"},    bus.overflow, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.af_valid     = 1'b0;
    bus.af_data      = '0;
    bus.output_wr_en = 1'b0;
    bus.output_sel   = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    // Five writes, commit, back-to-back reads of 0..4.
    for (int i = 1; i <= 5; i++) af_write(16'(i * 10));
    check("five_wr_count", bus.wr_count, 5);
    commit_pulse();
    check("five_layer_count", bus.layer_count, 5);
    check("five_wr_count_after", bus.wr_count, 0);
    for (int i = 0; i < 6; i++) begin
      bus.rd_en      = (i < 5);
      bus.rd_addr    = 6'(i);
      bus.output_sel = 1'b1;
      tick();
      if (i >= 1) begin
        check("b2b_valid", bus.rd_valid, 1);
        check("b2b_data", bus.rd_data, i * 10);
        check("b2b_oob", bus.rd_oob, 0);
      end
    end
    bus.rd_en = 1'b0;
    tick();
    check("b2b_valid_drop", bus.rd_valid, 0);

    // Held commit level swaps exactly once.
    af_write(16'd100);
    af_write(16'd200);
    af_write(16'd300);
    bus.output_wr_en = 1'b1;
    repeat (4) tick();
    bus.output_wr_en = 1'b0;
    tick();
    check("hold_layer_count", bus.layer_count, 3);
    check("hold_wr_count", bus.wr_count, 0);
    read_one(6'd0, 1'b1);
    check("hold_rd0", bus.rd_data, 100);
    read_one(6'd2, 1'b1);
    check("hold_rd2", bus.rd_data, 300);
    read_one(6'd3, 1'b1);
`ifdef ACTBUF_OVF_CHECK_EN
    check("hold_rd3_oob", bus.rd_oob, 1);
    check("hold_rd3_data", bus.rd_data, 0);
`else
    check("hold_rd3_oob", bus.rd_oob, 0);
`endif

    // Write and read coincident with the commit edge.
    af_write(16'd7);
    af_write(16'd8);
    af_write(16'd9);
    af_write(16'd10);
    check("coin_wr_count", bus.wr_count, 4);
    bus.af_valid     = 1'b1;
    bus.af_data      = 16'd11;
    bus.output_wr_en = 1'b1;
    bus.rd_en        = 1'b1;
    bus.rd_addr      = 6'd0;
    bus.output_sel   = 1'b1;
    tick();
    bus.af_valid     = 1'b0;
    bus.output_wr_en = 1'b0;
    bus.rd_en        = 1'b0;
    tick();
    check("coin_pre_bank_valid", bus.rd_valid, 1);
    check("coin_pre_bank_data", bus.rd_data, 100);
    check("coin_layer_count", bus.layer_count, 5);
    read_one(6'd4, 1'b1);
    check("coin_rd4", bus.rd_data, 11);
    read_one(6'd0, 1'b1);
    check("coin_rd0", bus.rd_data, 7);

    // External input path.
    bus.rd_en      = 1'b1;
    bus.rd_addr    = 6'd7;
    bus.output_sel = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    check("ext_addr_p1", bus.ext_addr, 7);
    check("ext_valid_p1", bus.rd_valid, 0);
    tick();
    check("ext_valid_p2", bus.rd_valid, 1);
    check("ext_data_p2", bus.rd_data, 16'h5007);
    check("ext_oob_p2", bus.rd_oob, 0);
    read_one(6'd40, 1'b0);
    check("ext40_data", bus.rd_data, 16'h5028);
    check("ext40_oob", bus.rd_oob, 0);

    // Fill the bank past DEPTH.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_layer_count", bus.layer_count, 0);
    check("start_wr_count", bus.wr_count, 0);
    for (int i = 0; i < 64; i++) af_write(16'(1000 + i));
    check("fill64_overflow", bus.overflow, 0);
`ifdef ACTBUF_OVF_CHECK_EN
    check("fill64_wr_count", bus.wr_count, 64);
`else
    check("fill64_wr_count", bus.wr_count, 0);
`endif
    af_write(16'd1064);
`ifdef ACTBUF_OVF_CHECK_EN
    check("fill65_wr_count", bus.wr_count, 64);
    check("fill65_overflow", bus.overflow, 1);
`else
    check("fill65_wr_count", bus.wr_count, 1);
    check("fill65_overflow", bus.overflow, 0);
`endif
    commit_pulse();
    read_one(6'd63, 1'b1);
    check("fill_rd63", bus.rd_data, 1063);
    check("fill_rd63_oob", bus.rd_oob, 0);
    read_one(6'd0, 1'b1);
`ifdef ACTBUF_OVF_CHECK_EN
    check("fill_layer_count", bus.layer_count, 64);
    check("fill_overflow_sticky", bus.overflow, 1);
    check("fill_rd0", bus.rd_data, 1000);
`else
    check("fill_layer_count", bus.layer_count, 1);
    check("fill_rd0", bus.rd_data, 1064);
`endif

    // Reset mid-layer.
    af_write(16'd555);
    af_write(16'd666);
    af_write(16'd777);
    check("mid_wr_count", bus.wr_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    read_one(6'd0, 1'b1);
    check("midrst_rd_valid", bus.rd_valid, 1);
`ifdef ACTBUF_OVF_CHECK_EN
    check("midrst_rd_oob", bus.rd_oob, 1);
    check("midrst_rd_data", bus.rd_data, 0);
`else
    check("midrst_rd_oob", bus.rd_oob, 0);
    check("midrst_rd_data", bus.rd_data, 555);
`endif

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
